// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control-bundle pipeline.
//   ctrl_t     9-bit decoded control bundle. The packed field order fixes the
//              bit positions: [8] reg_write, [7] mem2reg, [6] branch,
//              [5] mem_write, [4] mem_read, [3] alu_src, [2:1] alu_op,
//              [0] reg_dest.
//   BUBBLE     all-zero bundle; never writes, accesses memory or branches.
//   ALU_OP_*   alu_op encodings produced by the main decoder.
//   OPC_*      opcodes of the supported instruction subset.
package ctrl_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem2reg;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dest;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline register with synchronous reset, enable and
// flush.
//   i_clk     clock
//   i_rst     synchronous active-high reset (loads all zeros)
//   i_en      1 = load i_d, 0 = hold
//   i_flush   1 = load FLUSH_VAL (the stage's bubble); overrides i_en
//   i_d/o_q   W-bit data in / registered data out
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int             W         = CTRL_W,
  parameter logic [W-1:0]   FLUSH_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q <= FLUSH_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, resolves beq in MEM and keeps saturating
// stall / flush counters.
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_id_*                     decoder outputs and rs/rt/rd of the ID instruction
//   i_ex_alu_zero              ALU zero flag of the instruction in EX
//   o_ex_*, o_mem_*, o_wb_*    per-stage controls (registered)
//   o_ex_dst/o_mem_dst/o_wb_dst  resolved destination per stage (0 = none)
//   o_pc_write, o_ifid_write   0 = hold PC / IF-ID (load-use stall)
//   o_ifid_flush               1 = clear IF/ID (taken branch)
//   o_branch_taken             beq in MEM with zero set
//   o_stall_cnt, o_flush_cnt   saturating performance counters
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem2reg,
  input  logic             i_id_branch,
  input  logic             i_id_mem_write,
  input  logic             i_id_mem_read,
  input  logic             i_id_alu_src,
  input  logic [1:0]       i_id_alu_op,
  input  logic             i_id_reg_dest,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_ex_alu_zero,
  output logic             o_ex_alu_src,
  output logic [1:0]       o_ex_alu_op,
  output logic             o_ex_reg_dest,
  output logic             o_mem_branch,
  output logic             o_mem_write,
  output logic             o_mem_read,
  output logic             o_wb_reg_write,
  output logic             o_wb_mem2reg,
  output logic [REG_W-1:0] o_ex_dst,
  output logic [REG_W-1:0] o_mem_dst,
  output logic [REG_W-1:0] o_wb_dst,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_branch_taken,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int IDEX_W  = CTRL_W + 3 * REG_W;
  localparam int EXMEM_W = 5 + REG_W + 1;
  localparam int MEMWB_W = 2 + REG_W;

  localparam logic [IDEX_W-1:0] IDEX_BUBBLE = {BUBBLE, {(3 * REG_W){1'b0}}};

  ctrl_t              w_id_ctrl;
  logic [IDEX_W-1:0]  w_idex_d;
  logic [IDEX_W-1:0]  w_idex_q;
  ctrl_t              w_ex_ctrl;
  logic [REG_W-1:0]   w_ex_rs_unused;
  logic [REG_W-1:0]   w_ex_rt;
  logic [REG_W-1:0]   w_ex_rd;
  logic               w_ex_reg_dest;
  logic [REG_W-1:0]   w_ex_dst;

  logic [EXMEM_W-1:0] w_exmem_d;
  logic [EXMEM_W-1:0] w_exmem_q;
  logic               w_mem_reg_write;
  logic               w_mem_mem2reg;
  logic               w_mem_branch;
  logic               w_mem_write;
  logic               w_mem_read;
  logic [REG_W-1:0]   w_mem_dst;
  logic               w_mem_zero;

  logic [MEMWB_W-1:0] w_memwb_d;
  logic [MEMWB_W-1:0] w_memwb_q;
  logic               w_wb_reg_write;
  logic               w_wb_mem2reg;
  logic [REG_W-1:0]   w_wb_dst;

  logic               w_hazard;
  logic               w_taken;
  logic               w_stall;

  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  always_comb begin
    w_id_ctrl           = BUBBLE;
    w_id_ctrl.reg_write = i_id_reg_write;
    w_id_ctrl.mem2reg   = i_id_mem2reg;
    w_id_ctrl.branch    = i_id_branch;
    w_id_ctrl.mem_write = i_id_mem_write;
    w_id_ctrl.mem_read  = i_id_mem_read;
    w_id_ctrl.alu_src   = i_id_alu_src;
    w_id_ctrl.alu_op    = i_id_alu_op;
    w_id_ctrl.reg_dest  = i_id_reg_dest;
  end

  // ID/EX: a stall or a taken branch replaces the incoming instruction with a
  // bubble; a flush takes priority but both load the same bubble.
  assign w_idex_d = {w_id_ctrl, i_id_rs, i_id_rt, i_id_rd};

  ctrl_stage_reg #(.W(IDEX_W), .FLUSH_VAL(IDEX_BUBBLE)) u_idex (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (w_stall | w_taken),
    .i_d     (w_idex_d),
    .o_q     (w_idex_q)
  );

  // rs rides along with the bundle for a forwarding unit; nothing here uses it.
  assign {w_ex_ctrl, w_ex_rs_unused, w_ex_rt, w_ex_rd} = w_idex_q;

  // Gating with reg_write keeps a don't-care reg_dest (beq/sw) off every output.
  assign w_ex_reg_dest = w_ex_ctrl.reg_write & w_ex_ctrl.reg_dest;
  assign w_ex_dst      = !w_ex_ctrl.reg_write ? '0 :
                         (w_ex_ctrl.reg_dest ? w_ex_rd : w_ex_rt);

  assign w_exmem_d = {w_ex_ctrl.reg_write, w_ex_ctrl.mem2reg, w_ex_ctrl.branch,
                      w_ex_ctrl.mem_write, w_ex_ctrl.mem_read, w_ex_dst,
                      i_ex_alu_zero};

  ctrl_stage_reg #(.W(EXMEM_W), .FLUSH_VAL('0)) u_exmem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (w_taken),
    .i_d     (w_exmem_d),
    .o_q     (w_exmem_q)
  );

  assign {w_mem_reg_write, w_mem_mem2reg, w_mem_branch, w_mem_write,
          w_mem_read, w_mem_dst, w_mem_zero} = w_exmem_q;

  assign w_memwb_d = {w_mem_reg_write, w_mem_mem2reg, w_mem_dst};

  ctrl_stage_reg #(.W(MEMWB_W), .FLUSH_VAL('0)) u_memwb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .i_flush (1'b0),
    .i_d     (w_memwb_d),
    .o_q     (w_memwb_q)
  );

  assign {w_wb_reg_write, w_wb_mem2reg, w_wb_dst} = w_memwb_q;

  assign w_hazard = w_ex_ctrl.mem_read && (w_ex_rt != '0) &&
                    ((w_ex_rt == i_id_rs) || (w_ex_rt == i_id_rt));
  assign w_taken  = w_mem_branch & w_mem_zero;
  // The flush discards the instruction that would have stalled.
  assign w_stall  = w_hazard & ~w_taken;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ex_alu_src   = w_ex_ctrl.alu_src;
  assign o_ex_alu_op    = w_ex_ctrl.alu_op;
  assign o_ex_reg_dest  = w_ex_reg_dest;
  assign o_ex_dst       = w_ex_dst;
  assign o_mem_branch   = w_mem_branch;
  assign o_mem_write    = w_mem_write;
  assign o_mem_read     = w_mem_read;
  assign o_mem_dst      = w_mem_dst;
  assign o_wb_reg_write = w_wb_reg_write;
  assign o_wb_mem2reg   = w_wb_mem2reg;
  assign o_wb_dst       = w_wb_dst;
  assign o_pc_write     = ~w_stall;
  assign o_ifid_write   = ~w_stall;
  assign o_ifid_flush   = w_taken;
  assign o_branch_taken = w_taken;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Downstream consumer of the main decoder's control bundle in the 5-stage pipelined MIPS core.
- Carries decoded controls from ID through the ID/EX, EX/MEM and MEM/WB registers and presents each field in the stage that uses it.
- Detects load-use hazards and issues stalls; resolves beq in MEM and issues flushes.
- Keeps saturating stall and flush counters for lab performance reporting.

Parameters:
CNT_W, 16, width of the stall and flush performance counters
REG_W, 5, register-specifier width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_reg_write  in  1  decoder output for the instruction in ID
id_mem2reg  in  1  decoder output
id_branch  in  1  decoder output
id_mem_write  in  1  decoder output
id_mem_read  in  1  decoder output
id_alu_src  in  1  decoder output
id_alu_op  in  2  decoder output
id_reg_dest  in  1  decoder output; may be X for beq/sw
id_rs, id_rt, id_rd  in  REG_W each  register fields of the ID instruction
ex_alu_zero  in  1  ALU zero flag of the instruction currently in EX
ex_alu_src, ex_alu_op, ex_reg_dest  out  1/2/1  EX-stage controls
mem_branch, mem_write, mem_read  out  1 each  MEM-stage controls
wb_reg_write, wb_mem2reg  out  1 each  WB-stage controls
ex_dst, mem_dst, wb_dst  out  REG_W each  resolved destination register per stage
pc_write  out  1  0 = hold PC
ifid_write  out  1  0 = hold IF/ID
ifid_flush  out  1  1 = clear IF/ID to a nop
branch_taken  out  1  mem_branch & registered zero
stall_cnt  out  CNT_W  number of stall cycles
flush_cnt  out  CNT_W  number of taken branches

Behaviour:
- Reset: all stage registers, all outputs and both counters clear to 0. Exception: pc_write and ifid_write are 1 in the cycle after reset.
- Pipeline registers:
  - ID/EX captures the full bundle plus rs/rt/rd.
  - EX/MEM captures the MEM and WB fields, the resolved destination and ex_alu_zero.
  - MEM/WB captures the WB fields and the destination.
  - Latency: ID→EX 1 cycle, ID→MEM 2, ID→WB 3. No combinational path from id_* to any stage output.
- Destination resolution in EX: dst = ex_reg_dest ? rd : rt.
  - If the EX reg_write is 0, dst and ex_reg_dest are forced to 0.
  - An X on id_reg_dest must never reach any output.
- Load-use hazard (combinational from ID/EX):
  - hazard = ex mem_read & (ex rt != 0) & (ex rt == id_rs | ex rt == id_rt).
  - On hazard: pc_write=0 and ifid_write=0; ID/EX loads a bubble (all controls 0) on the next edge. EX/MEM and MEM/WB advance normally.
  - The stall lasts exactly one cycle per load-use pair.
- Branch:
  - branch_taken = EX/MEM branch & EX/MEM zero.
  - When branch_taken=1: ifid_flush=1, and ID/EX and EX/MEM both load bubbles on the next edge. MEM/WB advances normally (the beq itself writes nothing).
- Stall and flush in the same cycle: flush wins. pc_write=1, ifid_write=1, ifid_flush=1, and stall_cnt does not increment.
- A bubble is all-zero controls with dst=0. It never causes a register write, memory access or branch.
- Counters:
  - stall_cnt increments once per stall cycle; flush_cnt increments once per taken branch.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Reset mid-operation: the next edge clears every stage, so in-flight instructions are discarded without side effects.

Decomposition:
- Shared package (ctrl_pkg):
  - Bundle width (9 bits) and field bit positions.
  - ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_RTYPE=2'b10.
  - BUBBLE bundle constant.
  - Opcode constants 0x00/0x04/0x08/0x23/0x2B.
- One sub-module, ctrl_stage_reg: a parameterised-width register with rst, en and flush. flush loads BUBBLE; en=0 holds. It is instantiated three times.
- Hazard, branch and counter logic stay in ctrl_pipe.

Test Plan:
- Reset, then an R-type bundle (reg_write=1, alu_op=10, reg_dest=1, rd=5): ex_alu_op=10 and ex_dst=5 at cycle 1, wb_reg_write=1 and wb_dst=5 at cycle 3, stall_cnt=0.
- lw rt=8 followed by an add with rs=8: pc_write=0 and ifid_write=0 for exactly one cycle; the add reaches EX one cycle late with a bubble ahead of it; stall_cnt=1.
- lw rt=0 followed by a use of rs=0: no stall; pc_write stays 1.
- beq with ex_alu_zero=1: branch_taken=1 two cycles after ID, ifid_flush=1, the two following instructions never reach MEM/WB, flush_cnt=1. Repeat with zero=0: no flush.
- Taken branch in MEM while a load-use hazard is present in ID: flush wins, pc_write=1, stall_cnt unchanged.
- sw with id_reg_dest=X: ex_dst, mem_dst and wb_dst read 0 with no X. Preload stall_cnt to 0xFFFF and force a stall: the count stays 0xFFFF.
